// File: rtl/rv_encode_pkg.sv
// rv_encode_pkg: format codes, RV32I opcodes, NOP word and immediate range limits for the instruction encoder
package rv_encode_pkg;
   typedef enum logic [2:0] {
      FMT_I_ALU  = 3'd0,
      FMT_LOAD   = 3'd1,
      FMT_STORE  = 3'd2,
      FMT_BRANCH = 3'd3,
      FMT_JAL    = 3'd4
   } fmt_e;
   localparam logic [6:0]  OPC_I_ALU  = 7'b0010011;
   localparam logic [6:0]  OPC_LOAD   = 7'b0000011;
   localparam logic [6:0]  OPC_STORE  = 7'b0100011;
   localparam logic [6:0]  OPC_BRANCH = 7'b1100011;
   localparam logic [6:0]  OPC_JAL    = 7'b1101111;
   localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;
   localparam int IMM12_MIN = -2048;
   localparam int IMM12_MAX = 2047;
   localparam int IMM13_MIN = -4096;
   localparam int IMM13_MAX = 4094;
   localparam int IMM21_MIN = -1048576;
   localparam int IMM21_MAX = 1048574;
   function automatic logic [6:0] fmt_opcode(input logic [2:0] f);
      return (f == FMT_LOAD)   ? OPC_LOAD   :
             (f == FMT_STORE)  ? OPC_STORE  :
             (f == FMT_BRANCH) ? OPC_BRANCH :
             (f == FMT_JAL)    ? OPC_JAL    : OPC_I_ALU;
   endfunction
endpackage

// File: rtl/imm_range_check.sv
// imm_range_check: decides whether an immediate is encodable in the given instruction format
module imm_range_check
   import rv_encode_pkg::*;
(
   input  logic [2:0]  i_fmt,
   input  logic [31:0] i_imm,
   output logic        o_ok
);
   logic signed [31:0] w_simm;
   logic               w_in12;
   logic               w_in13;
   logic               w_in21;
   assign w_simm = i_imm;
   assign w_in12 = (w_simm >= IMM12_MIN) && (w_simm <= IMM12_MAX);
   assign w_in13 = (w_simm >= IMM13_MIN) && (w_simm <= IMM13_MAX) && !i_imm[0];
   assign w_in21 = (w_simm >= IMM21_MIN) && (w_simm <= IMM21_MAX) && !i_imm[0];
   assign o_ok = (i_fmt == FMT_I_ALU || i_fmt == FMT_LOAD || i_fmt == FMT_STORE) ? w_in12 :
                 (i_fmt == FMT_BRANCH) ? w_in13 :
                 (i_fmt == FMT_JAL)    ? w_in21 : 1'b0;
endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: packs requests into RV32I words and emits (address, word) IMEM write beats through a 2-stage pipeline
module instr_encoder
   import rv_encode_pkg::*;
#(
   parameter int ADDR_W    = 8,
   parameter int BASE_ADDR = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_restart,
   input  logic              i_in_valid,
   output logic              o_in_ready,
   input  logic [2:0]        i_in_fmt,
   input  logic [4:0]        i_in_rd,
   input  logic [4:0]        i_in_rs1,
   input  logic [4:0]        i_in_rs2,
   input  logic [2:0]        i_in_funct3,
   input  logic [31:0]       i_in_imm,
   output logic              o_out_valid,
   input  logic              i_out_ready,
   output logic [31:0]       o_out_instr,
   output logic [ADDR_W-1:0] o_out_addr,
   output logic              o_out_err,
   output logic [7:0]        o_err_count
);
   logic              r_s1_valid;
   logic              r_s1_ok;
   logic [2:0]        r_s1_fmt;
   logic [2:0]        r_s1_f3;
   logic [4:0]        r_s1_rd;
   logic [4:0]        r_s1_rs1;
   logic [4:0]        r_s1_rs2;
   logic [20:0]       r_s1_imm;
   logic              r_s2_valid;
   logic              r_s2_err;
   logic [31:0]       r_s2_instr;
   logic [ADDR_W-1:0] r_count;
   logic [7:0]        r_err_cnt;
   logic              w_s2_adv;
   logic              w_s1_adv;
   logic              w_accept;
   logic              w_fire;
   logic              w_ok;
   logic [6:0]        w_opc;
   logic [31:0]       w_i;
   logic [31:0]       w_s;
   logic [31:0]       w_b;
   logic [31:0]       w_j;
   logic [31:0]       w_instr;
   imm_range_check u_chk (
      .i_fmt (i_in_fmt),
      .i_imm (i_in_imm),
      .o_ok  (w_ok)
   );
   assign w_s2_adv    = !r_s2_valid || i_out_ready;
   assign w_s1_adv    = !r_s1_valid || w_s2_adv;
   assign w_accept    = i_in_valid && w_s1_adv;
   assign w_fire      = r_s2_valid && i_out_ready;
   assign o_in_ready  = w_s1_adv;
   assign o_out_valid = r_s2_valid;
   assign o_out_instr = r_s2_instr;
   assign o_out_err   = r_s2_err;
   assign o_err_count = r_err_cnt;
   assign o_out_addr  = ADDR_W'(BASE_ADDR) + r_count;
   // field packing for every format; a rejected request becomes a NOP
   always_comb begin
      w_opc   = fmt_opcode(r_s1_fmt);
      w_i     = {r_s1_imm[11:0], r_s1_rs1, r_s1_f3, r_s1_rd, w_opc};
      w_s     = {r_s1_imm[11:5], r_s1_rs2, r_s1_rs1, r_s1_f3, r_s1_imm[4:0], w_opc};
      w_b     = {r_s1_imm[12], r_s1_imm[10:5], r_s1_rs2, r_s1_rs1, r_s1_f3, r_s1_imm[4:1], r_s1_imm[11], w_opc};
      w_j     = {r_s1_imm[20], r_s1_imm[10:1], r_s1_imm[11], r_s1_imm[19:12], r_s1_rd, w_opc};
      w_instr = !r_s1_ok                  ? NOP_INSTR :
                (r_s1_fmt == FMT_STORE)  ? w_s :
                (r_s1_fmt == FMT_BRANCH) ? w_b :
                (r_s1_fmt == FMT_JAL)    ? w_j : w_i;
   end
   // pipeline valid bits and the output stage; reset drops any in-flight beats
   always_ff @(posedge clk) begin
      if (rst) begin
         r_s1_valid <= 1'b0;
         r_s2_valid <= 1'b0;
         r_s2_instr <= '0;
         r_s2_err   <= 1'b0;
      end else begin
         if (w_s1_adv) r_s1_valid <= i_in_valid;
         if (w_s2_adv) r_s2_valid <= r_s1_valid;
         if (w_s2_adv && r_s1_valid) begin
            r_s2_instr <= w_instr;
            r_s2_err   <= !r_s1_ok;
         end
      end
   end
   // stage 1 payload capture; qualified by r_s1_valid so it needs no reset
   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_s1_fmt <= i_in_fmt;
         r_s1_f3  <= i_in_funct3;
         r_s1_rd  <= i_in_rd;
         r_s1_rs1 <= i_in_rs1;
         r_s1_rs2 <= i_in_rs2;
         r_s1_imm <= i_in_imm[20:0];
         r_s1_ok  <= w_ok;
      end
   end
   // address counter (restart beats a simultaneous handshake) and saturating error counter
   always_ff @(posedge clk) begin
      if (rst) begin
         r_count   <= '0;
         r_err_cnt <= '0;
      end else begin
         if (i_restart) r_count <= '0;
         else if (w_fire) r_count <= r_count + 1'b1;
         if (w_accept && !w_ok && r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
      end
   end
endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: directed and random scoreboard bench for instr_encoder
module tb_instr_encoder;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        i_restart = 1'b0;
   logic        i_in_valid = 1'b0;
   logic        o_in_ready;
   logic [2:0]  i_in_fmt = '0;
   logic [4:0]  i_in_rd = '0;
   logic [4:0]  i_in_rs1 = '0;
   logic [4:0]  i_in_rs2 = '0;
   logic [2:0]  i_in_funct3 = '0;
   logic [31:0] i_in_imm = '0;
   logic        o_out_valid;
   logic        i_out_ready = 1'b1;
   logic [31:0] o_out_instr;
   logic [7:0]  o_out_addr;
   logic        o_out_err;
   logic [7:0]  o_err_count;
   typedef struct packed {
      logic [2:0]  fmt;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [2:0]  f3;
      logic [31:0] imm;
      logic        err;
      logic        exact;
      logic [31:0] instr;
   } exp_t;
   exp_t q[$];
   exp_t pend;
   int   vectors = 0;
   int   miscompares = 0;
   int   m_cnt = 0;
   int   cyc = 0;
   int   t0;
   logic bp_en = 1'b0;
   instr_encoder #(.ADDR_W(8), .BASE_ADDR(0)) dut (
      .clk         (clk),
      .rst         (rst),
      .i_restart   (i_restart),
      .i_in_valid  (i_in_valid),
      .o_in_ready  (o_in_ready),
      .i_in_fmt    (i_in_fmt),
      .i_in_rd     (i_in_rd),
      .i_in_rs1    (i_in_rs1),
      .i_in_rs2    (i_in_rs2),
      .i_in_funct3 (i_in_funct3),
      .i_in_imm    (i_in_imm),
      .o_out_valid (o_out_valid),
      .i_out_ready (i_out_ready),
      .o_out_instr (o_out_instr),
      .o_out_addr  (o_out_addr),
      .o_out_err   (o_out_err),
      .o_err_count (o_err_count)
   );
   always #5 clk = ~clk;
   always @(posedge clk) cyc++;
   always @(posedge clk) if (bp_en) begin
      #1;
      i_out_ready = 1'($urandom_range(0, 1));
   end
   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      assert (got === exp) else begin
         miscompares++;
         $error("FAIL %s: got %h exp %h", tag, got, exp);
      end
   endtask
   function automatic logic [6:0] opc(input logic [2:0] f);
      case (f)
         3'd1:    return 7'b0000011;
         3'd2:    return 7'b0100011;
         3'd3:    return 7'b1100011;
         3'd4:    return 7'b1101111;
         default: return 7'b0010011;
      endcase
   endfunction
   function automatic logic [31:0] dec_imm(input logic [2:0] f, input logic [31:0] w);
      case (f)
         3'd2:    return {{20{w[31]}}, w[31:25], w[11:7]};
         3'd3:    return {{20{w[31]}}, w[31], w[7], w[30:25], w[11:8]};
         3'd4:    return {{12{w[31]}}, w[31], w[19:12], w[20], w[30:21]};
         default: return {{20{w[31]}}, w[31:20]};
      endcase
   endfunction
   function automatic logic [31:0] fields(input logic [2:0] f, input logic [6:0] op, input logic [4:0] rd,
                                          input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3);
      logic has_rd, has_rs2, no_rs1;
      has_rd  = (f == 3'd0 || f == 3'd1 || f == 3'd4);
      has_rs2 = (f == 3'd2 || f == 3'd3);
      no_rs1  = (f == 3'd4);
      return {7'd0, op, has_rd ? rd : 5'd0, no_rs1 ? 5'd0 : rs1, no_rs1 ? 3'd0 : f3, has_rs2 ? rs2 : 5'd0};
   endfunction
   // scoreboard: compare each accepted output beat against the oldest expectation
   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         q.delete();
         m_cnt = 0;
      end else begin
         if (o_out_valid && i_out_ready) begin
            check("beat_expected", 32'(q.size() != 0), 32'd1);
            if (q.size() != 0) begin
               e = q.pop_front();
               if (e.err || e.exact) check("instr", o_out_instr, e.err ? 32'h0000_0013 : e.instr);
               else begin
                  check("roundtrip_imm", dec_imm(e.fmt, o_out_instr),
                        (e.fmt == 3'd3 || e.fmt == 3'd4) ? {e.imm[31], e.imm[31:1]} : e.imm);
                  check("fields", fields(e.fmt, o_out_instr[6:0], o_out_instr[11:7], o_out_instr[19:15],
                                         o_out_instr[24:20], o_out_instr[14:12]),
                        fields(e.fmt, opc(e.fmt), e.rd, e.rs1, e.rs2, e.f3));
               end
               check("err", 32'(o_out_err), 32'(e.err));
               check("addr", 32'(o_out_addr), 32'(m_cnt % 256));
            end
            m_cnt++;
         end
         if (i_restart) m_cnt = 0;
      end
   end
   task automatic drive(input logic [2:0] f, input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [2:0] f3, input logic [31:0] imm, input logic err, input logic exact,
                        input logic [31:0] instr);
      i_in_fmt = f; i_in_rd = rd; i_in_rs1 = rs1; i_in_rs2 = rs2; i_in_funct3 = f3; i_in_imm = imm;
      i_in_valid = 1'b1;
      pend = '{fmt: f, rd: rd, rs1: rs1, rs2: rs2, f3: f3, imm: imm, err: err, exact: exact, instr: instr};
   endtask
   task automatic wait_accept();
      for (int n = 0; n < 100; n++) begin
         @(negedge clk);
         if (o_in_ready) break;
      end
      check("accept_timeout", 32'(o_in_ready), 32'd1);
      q.push_back(pend);
      @(posedge clk);
      #1 i_in_valid = 1'b0;
   endtask
   task automatic send_x(input logic [2:0] f, input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [2:0] f3, input logic [31:0] imm, input logic [31:0] instr);
      drive(f, rd, rs1, rs2, f3, imm, 1'b0, 1'b1, instr);
      wait_accept();
   endtask
   task automatic send_r(input logic [2:0] f, input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [2:0] f3, input logic [31:0] imm);
      drive(f, rd, rs1, rs2, f3, imm, 1'b0, 1'b0, 32'd0);
      wait_accept();
   endtask
   task automatic send_e(input logic [2:0] f, input logic [31:0] imm);
      drive(f, 5'd3, 5'd4, 5'd5, 3'd1, imm, 1'b1, 1'b1, 32'd0);
      wait_accept();
   endtask
   task automatic drain();
      for (int n = 0; n < 500 && q.size() != 0; n++) @(negedge clk);
      check("drain", 32'(q.size()), 32'd0);
      @(posedge clk);
      #1;
   endtask
   initial begin
      int f, v;
      repeat (3) @(posedge clk);
      #1;
      check("rst_out_valid", 32'(o_out_valid), 32'd0);
      check("rst_out_instr", o_out_instr, 32'd0);
      check("rst_out_addr", 32'(o_out_addr), 32'd0);
      check("rst_out_err", 32'(o_out_err), 32'd0);
      check("rst_err_count", 32'(o_err_count), 32'd0);
      rst = 1'b0;
      t0 = cyc;
      send_x(3'd0, 5'd1, 5'd0, 5'd0, 3'd0, 32'd5, 32'h0050_0093);
      send_x(3'd2, 5'd0, 5'd1, 5'd2, 3'd2, 32'd8, 32'h0020_A423);
      send_x(3'd3, 5'd0, 5'd1, 5'd2, 3'd0, -32'sd4, 32'hFE20_8EE3);
      send_x(3'd4, 5'd1, 5'd0, 5'd0, 3'd0, 32'd2048, 32'h0010_00EF);
      check("full_rate_cycles", 32'(cyc - t0), 32'd4);
      drain();
      send_e(3'd0, 32'd2048);
      send_e(3'd3, 32'd3);
      send_e(3'd6, 32'd0);
      drain();
      check("err_count_3", 32'(o_err_count), 32'd3);
      send_r(3'd0, 5'd7, 5'd8, 5'd0, 3'd4, -32'sd2048);
      send_r(3'd1, 5'd9, 5'd10, 5'd0, 3'd2, 32'd2047);
      send_r(3'd2, 5'd0, 5'd11, 5'd12, 3'd1, -32'sd2048);
      send_r(3'd3, 5'd0, 5'd13, 5'd14, 3'd5, -32'sd4096);
      send_r(3'd3, 5'd0, 5'd15, 5'd16, 3'd7, 32'd4094);
      send_r(3'd4, 5'd31, 5'd0, 5'd0, 3'd0, -32'sd1048576);
      send_r(3'd4, 5'd17, 5'd0, 5'd0, 3'd0, 32'd1048574);
      send_e(3'd2, -32'sd2049);
      send_e(3'd3, 32'd4096);
      send_e(3'd4, 32'd1048576);
      send_e(3'd4, 32'd5);
      send_e(3'd5, 32'd0);
      drain();
      check("err_count_8", 32'(o_err_count), 32'd8);
      bp_en = 1'b1;
      for (int i = 0; i < 40; i++) begin
         f = int'($urandom_range(0, 4));
         v = (f <= 2) ? int'($urandom_range(0, 4095)) - 2048 :
             (f == 3) ? (int'($urandom_range(0, 4095)) - 2048) * 2 :
                        (int'($urandom_range(0, 1048575)) - 524288) * 2;
         send_r(3'(f), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                3'($urandom_range(0, 7)), 32'(v));
      end
      bp_en = 1'b0;
      @(posedge clk);
      #2 i_out_ready = 1'b1;
      drain();
      for (int i = 0; i < 300; i++) send_e(3'd7, 32'(i));
      drain();
      check("err_count_sat", 32'(o_err_count), 32'd255);
      @(posedge clk);
      #1 i_out_ready = 1'b0;
      send_x(3'd0, 5'd1, 5'd0, 5'd0, 3'd0, 32'd5, 32'h0050_0093);
      send_x(3'd2, 5'd0, 5'd1, 5'd2, 3'd2, 32'd8, 32'h0020_A423);
      drive(3'd4, 5'd1, 5'd0, 5'd0, 3'd0, 32'd2048, 1'b0, 1'b1, 32'h0010_00EF);
      repeat (3) @(negedge clk);
      check("stall_in_ready", 32'(o_in_ready), 32'd0);
      check("stall_out_valid", 32'(o_out_valid), 32'd1);
      check("stall_out_instr", o_out_instr, 32'h0050_0093);
      @(posedge clk);
      #1 i_out_ready = 1'b1;
      wait_accept();
      drain();
      i_restart = 1'b1;
      @(posedge clk);
      #1 i_restart = 1'b0;
      check("restart_idle_addr", 32'(o_out_addr), 32'd0);
      send_r(3'd0, 5'd2, 5'd3, 5'd0, 3'd0, 32'd1);
      send_r(3'd0, 5'd4, 5'd5, 5'd0, 3'd0, 32'd2);
      send_r(3'd0, 5'd6, 5'd7, 5'd0, 3'd0, 32'd3);
      check("restart_with_beat", 32'(o_out_valid), 32'd1);
      i_restart = 1'b1;
      @(posedge clk);
      #1 i_restart = 1'b0;
      check("restart_addr", 32'(o_out_addr), 32'd0);
      drain();
      i_out_ready = 1'b0;
      send_r(3'd1, 5'd1, 5'd2, 5'd0, 3'd3, 32'd16);
      send_r(3'd1, 5'd1, 5'd2, 5'd0, 3'd3, 32'd20);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      check("rst_mid_out_valid", 32'(o_out_valid), 32'd0);
      check("rst_mid_addr", 32'(o_out_addr), 32'd0);
      check("rst_mid_err_count", 32'(o_err_count), 32'd0);
      check("rst_mid_in_ready", 32'(o_in_ready), 32'd1);
      i_out_ready = 1'b1;
      send_x(3'd0, 5'd1, 5'd0, 5'd0, 3'd0, 32'd5, 32'h0050_0093);
      drain();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
